tpu_loader: RTL and testbench

Host-side sequencer directly upstream of the systolic-array TPU core. It accepts A and B operand rows on a ready/valid stream and writes them into the core's memory-mapped A/B buffers. It then issues the matmul strobe, waits out the systolic latency, and reads the C result rows back out onto a ready/valid output stream. It is the only master of the core's `r_w` / `addr` / `dataIn` bus.

---
 rtl/tpu_pkg.sv | 40 ++++
 rtl/tpu_out_reg.sv | 27 ++
 rtl/tpu_loader.sv | 161 ++++++++++++++++
 tb/tb_tpu_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU host loader: FSM states, core address map, job geometry.
// The optional C-clear phase is selected by TPU_LOADER_CCLEAR_EN in tpu_loader.
package tpu_pkg;

  localparam int DIM        = 8;
  localparam int BITS_C     = 16;
  localparam int ADDRW      = 16;
  localparam int DATAW      = 64;
  localparam int ROW_LAST   = DIM - 1;
  localparam int C_PER_HALF = DATAW / BITS_C;
  localparam int C_BEATS    = DIM * DIM / C_PER_HALF;
  localparam int WAIT_CYCLES = 3 * DIM;
  localparam int WAIT_W     = $clog2(WAIT_CYCLES);

  localparam logic [ADDRW-1:0] TPU_A_BASE  = 16'h0100;
  localparam logic [ADDRW-1:0] TPU_B_BASE  = 16'h0200;
  localparam logic [ADDRW-1:0] TPU_C_BASE  = 16'h0300;
  localparam logic [ADDRW-1:0] TPU_MM_ADDR = 16'h0400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CLR,
    S_START,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  function automatic logic [ADDRW-1:0] a_addr(input logic [2:0] row);
    return TPU_A_BASE | {10'b0, row, 3'b0};
  endfunction

  // Half-row index 2r+h maps straight onto r<<4 | h<<3.
  function automatic logic [ADDRW-1:0] c_addr(input logic [3:0] half);
    return TPU_C_BASE | {9'b0, half, 3'b0};
  endfunction

endpackage

// File: rtl/tpu_out_reg.sv
// Single-entry output holding register: loads one C half-row and holds it until the consumer takes it.
module tpu_out_reg
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DATAW-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [DATAW-1:0] data
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tpu_loader.sv
// Host-side sequencer for the systolic TPU core: streams A/B rows in, starts the matmul, streams C out.
// Define TPU_LOADER_CCLEAR_EN to zero C before every matmul; otherwise C accumulates across jobs.
module tpu_loader
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  state_t            state;
  logic [3:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      done      <= 1'b0;
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
    end else begin
      // NOTE: defaults first, so pulses and the bus fall back to idle unless a state drives them.
      in_ready  <= 1'b0;
      done      <= 1'b0;
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;

      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            tpu_r_w   <= 1'b1;
            tpu_addr  <= a_addr(idx[2:0]);
            tpu_wdata <= in_data;
            idx       <= idx + 4'd1;
            state     <= S_LOAD_A;
          end
        end

        S_LOAD_A: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            tpu_r_w   <= 1'b1;
            tpu_addr  <= a_addr(idx[2:0]);
            tpu_wdata <= in_data;
            if (idx == 4'(ROW_LAST)) begin
              idx   <= '0;
              state <= S_LOAD_B;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        S_LOAD_B: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            tpu_r_w   <= 1'b1;
            tpu_addr  <= TPU_B_BASE;
            tpu_wdata <= in_data;
            if (idx == 4'(ROW_LAST)) begin
              idx      <= '0;
              in_ready <= 1'b0;
`ifdef TPU_LOADER_CCLEAR_EN
              state    <= S_CLR;
`else
              state    <= S_START;
`endif
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

`ifdef TPU_LOADER_CCLEAR_EN
        S_CLR: begin
          tpu_r_w  <= 1'b1;
          tpu_addr <= c_addr(idx);
          if (idx == 4'(C_BEATS - 1)) begin
            idx   <= '0;
            state <= S_START;
          end else begin
            idx <= idx + 4'd1;
          end
        end
`endif

        S_START: begin
          tpu_r_w  <= 1'b1;
          tpu_addr <= TPU_MM_ADDR;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        // The read address is launched here so it is stable for the whole READ cycle.
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) begin
            tpu_addr <= c_addr(idx);
            state    <= S_READ;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_READ: begin
          state <= S_DRAIN;
        end

        S_DRAIN: begin
          if (out_fire) begin
            if (idx == 4'(C_BEATS - 1)) begin
              idx      <= '0;
              done     <= 1'b1;
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              idx      <= idx + 4'd1;
              tpu_addr <= c_addr(idx + 4'd1);
              state    <= S_READ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  tpu_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (state == S_READ),
    .load_data (tpu_rdata),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data)
  );

endmodule

// File: tb/tb_tpu_loader.sv
// Self-checking bench for tpu_loader: behavioural core model, matrix reference model and scoreboards.
module tb_tpu_loader;

  localparam int N      = 8;
  localparam int BEATS  = 16;
  localparam int WAIT_C = 3 * N;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] data;
  } bus_op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
  logic        done;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;

  int checks = 0;
  int errors = 0;

  tpu_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .tpu_r_w   (tpu_r_w),
    .tpu_addr  (tpu_addr),
    .tpu_wdata (tpu_wdata),
    .tpu_rdata (tpu_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural TPU core ----------------
  logic [63:0] core_a [N];
  logic [63:0] core_b [N];
  logic [15:0] core_c [64];

  function automatic logic [15:0] core_mac(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += int'($signed(core_a[i][8*k +: 8])) * int'($signed(core_b[k][8*j +: 8]));
    return 16'(s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) core_c[i] <= '0;
    end else if (tpu_r_w) begin
      if (tpu_addr[15:8] == 8'h01) begin
        core_a[tpu_addr[5:3]] <= tpu_wdata;
      end else if (tpu_addr == 16'h0200) begin
        for (int k = 0; k < N - 1; k++) core_b[k] <= core_b[k+1];
        core_b[N-1] <= tpu_wdata;
      end else if (tpu_addr[15:8] == 8'h03) begin
        for (int e = 0; e < 4; e++) core_c[{tpu_addr[6:3], 2'(e)}] <= tpu_wdata[16*e +: 16];
      end else if (tpu_addr == 16'h0400) begin
        for (int i = 0; i < 64; i++) core_c[i] <= core_c[i] + core_mac(i / 8, i % 8);
      end
    end
  end

  always_comb begin
    tpu_rdata = '0;
    if (tpu_addr[15:8] == 8'h03)
      for (int e = 0; e < 4; e++) tpu_rdata[16*e +: 16] = core_c[{tpu_addr[6:3], 2'(e)}];
  end

  // ---------------- reference model and scoreboards ----------------
  logic [63:0] job_a [N];
  logic [63:0] job_b [N];
  int          ref_acc [64];
  bus_op_t     bus_q [$];
  logic [63:0] exp_c_q [$];

  function automatic void push_bus(input logic rw, input logic [15:0] a, input logic [63:0] d);
    bus_op_t op;
    op.rw = rw; op.addr = a; op.data = d;
    bus_q.push_back(op);
  endfunction

  // Everything the job should do after its last input beat: clear, start, 16 reads, 16 C beats.
  task automatic push_job_tail();
    logic [63:0] beat;
`ifdef TPU_LOADER_CCLEAR_EN
    for (int h = 0; h < BEATS; h++) push_bus(1'b1, 16'h0300 + 16'(h * 8), 64'h0);
`endif
    push_bus(1'b1, 16'h0400, 64'h0);
    for (int h = 0; h < BEATS; h++) push_bus(1'b0, 16'h0300 + 16'(h * 8), 64'h0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(job_a[i][8*k +: 8])) * int'($signed(job_b[k][8*j +: 8]));
`ifdef TPU_LOADER_CCLEAR_EN
        ref_acc[i*N + j] = s;
`else
        ref_acc[i*N + j] = ref_acc[i*N + j] + s;
`endif
      end
    for (int h = 0; h < BEATS; h++) begin
      for (int e = 0; e < 4; e++) beat[16*e +: 16] = 16'(ref_acc[h*4 + e]);
      exp_c_q.push_back(beat);
    end
  endtask

  task automatic run_job(input int stall_pct);
    bit abort;
    abort = 0;
    for (int n = 0; n < 2 * N && !abort; n++) begin
      bit sent;
      int guard;
      sent = 0;
      guard = 0;
      while (!sent && !abort) begin
        @(negedge clk);
        in_data  = (n < N) ? job_a[n] : job_b[n - N];
        in_valid = ($urandom_range(99) >= stall_pct);
        if (in_valid && in_ready) begin
          sent = 1;
          if (n < N) push_bus(1'b1, 16'h0100 + 16'(n * 8), in_data);
          else       push_bus(1'b1, 16'h0200, in_data);
          if (n == 2 * N - 1) push_job_tail();
        end
        guard++;
        if (guard > 400) begin
          check("in_ready_timeout", 64'(sent), 64'h1);
          abort = 1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- monitors ----------------
  int cycle = 0;
  int mm_cycle = 0;
  bit mm_seen = 0;

  always @(negedge clk) begin
    bus_op_t e;
    cycle++;
    if (rst) begin
      mm_seen = 0;
    end else if (tpu_r_w || tpu_addr != 16'h0) begin
      check("bus_op_expected", 64'(bus_q.size() != 0), 64'h1);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        check("bus_rw_addr", {47'h0, tpu_r_w, tpu_addr}, {47'h0, e.rw, e.addr});
        check("bus_wdata", tpu_wdata, e.data);
        if (e.rw && e.addr == 16'h0400) begin
          mm_cycle = cycle;
          mm_seen  = 1;
        end else if (!e.rw && mm_seen) begin
          check("mm_latency_in_range",
                64'((cycle - mm_cycle) >= WAIT_C && (cycle - mm_cycle) <= WAIT_C + 1), 64'h1);
          mm_seen = 0;
        end
      end
    end else begin
      check("bus_idle_wdata", tpu_wdata, 64'h0);
    end
  end

  int          done_cnt = 0;
  int          beat_in_job = 0;
  bit          prev_hold = 0;
  bit          prev_done = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold   = 0;
      prev_done   = 0;
      beat_in_job = 0;
    end else begin
      if (out_valid) begin
        if (prev_hold) check("out_data_stable", out_data, prev_data);
        if (out_ready) begin
          check("c_beat_expected", 64'(exp_c_q.size() != 0), 64'h1);
          if (exp_c_q.size() != 0) check("c_beat", out_data, exp_c_q.pop_front());
          beat_in_job = (beat_in_job + 1) % BEATS;
          prev_hold = 0;
        end else begin
          prev_hold = 1;
          prev_data = out_data;
        end
      end else begin
        if (prev_hold) check("out_valid_dropped", 64'(out_valid), 64'h1);
        prev_hold = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_single_pulse", 64'(prev_done), 64'h0);
        check("done_idle_ready", {62'h0, busy, in_ready}, 64'h1);
        check("done_all_beats", 64'(exp_c_q.size()), 64'h0);
      end
      prev_done = done;
    end
  end

  bit bp_enable = 0;
  int bp_hold = 0;

  always @(posedge clk) begin
    #1;
    if (bp_enable && beat_in_job == 5 && out_valid && bp_hold < 20) begin
      out_ready = 1'b0;
      bp_hold++;
    end else begin
      out_ready = ($urandom_range(3) != 0);
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {58'h0, in_ready, out_valid, busy, done, tpu_r_w, 1'b0}, 64'h0);
    check({name, "_addr"}, 64'(tpu_addr), 64'h0);
    check({name, "_wdata"}, tpu_wdata, 64'h0);
    check({name, "_out_data"}, out_data, 64'h0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    bus_q.delete();
    exp_c_q.delete();
    for (int i = 0; i < 64; i++) ref_acc[i] = 0;
    #1;
    check_reset_outputs(name);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'h1);
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("job_done_reached", 64'(done_cnt >= target), 64'h1);
  endtask

  task automatic random_job();
    for (int r = 0; r < N; r++) begin
      job_a[r] = {$urandom, $urandom};
      job_b[r] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < 64; i++) ref_acc[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'h1);

    // Identity: C is all ones.
    for (int r = 0; r < N; r++) begin
      job_a[r] = 64'h1 << (8 * r);
      job_b[r] = 64'h0101_0101_0101_0101;
    end
    d0 = done_cnt;
    run_job(0);
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);
    #1;
    check("identity_done_count", 64'(done_cnt - d0), 64'h1);

    // Signed: row 0 of A is all -1, B all 2; fresh core C so row 0 reads -16.
    do_reset("pre_signed");
    for (int r = 0; r < N; r++) begin
      job_a[r] = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      job_b[r] = 64'h0202_0202_0202_0202;
    end
    d0 = done_cnt;
    run_job(0);
    wait_done(d0 + 1);

    // Back-to-back: second job issued while the first is still draining.
    random_job();
    d0 = done_cnt;
    run_job(20);
    run_job(20);
    wait_done(d0 + 2);

    // Backpressure on beat 5.
    random_job();
    bp_hold = 0;
    bp_enable = 1;
    d0 = done_cnt;
    run_job(0);
    wait_done(d0 + 1);
    bp_enable = 0;
    check("bp_hold_applied", 64'(bp_hold), 64'd20);

    // Heavy input stalls.
    for (int t = 0; t < 2; t++) begin
      random_job();
      d0 = done_cnt;
      run_job(60);
      wait_done(d0 + 1);
    end

    // Reset in the middle of WAIT, then a complete job.
    random_job();
    run_job(0);
    repeat (18) @(negedge clk);
    #1;
    check("busy_before_reset", {62'h0, busy, in_ready}, 64'h2);
    do_reset("mid_wait");
    random_job();
    d0 = done_cnt;
    run_job(30);
    wait_done(d0 + 1);

    repeat (5) @(negedge clk);
    check("bus_queue_drained", 64'(bus_q.size()), 64'h0);
    check("c_queue_drained", 64'(exp_c_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
